// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and helpers for the hazard scoreboard
// Contents: halt_state_t, producer kind encodings, default gap constants,
// age_w() counter-width helper and imax() for sizing the shared age counters.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  localparam logic KIND_ALU  = 1'b0;
  localparam logic KIND_LOAD = 1'b1;

  localparam int DEF_ALU_GAP        = 1;
  localparam int DEF_LOAD_GAP       = 2;
  localparam int DEF_LOAD_STORE_GAP = 1;
  localparam int DEF_BR_GAP         = 3;
  localparam int DEF_FLAG_GAP       = 2;
  localparam int DEF_PIPE_DEPTH     = 4;

  // Bits needed to hold 0..age_max; never narrower than one bit.
  function automatic int age_w(input int age_max);
    return (age_max < 1) ? 1 : $clog2(age_max + 1);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_age_ctr.sv
// rtl/hazard_age_ctr.sv - saturating age counter with load-to-one and hold
// Ports: clk, rst_n (sync, active-low, resets to MAX = ready),
//        load_one (new producer issued: age <= 1), hold (pipeline frozen),
//        age (current age, saturates at MAX).
module hazard_age_ctr #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_one,
  input  logic         hold,
  output logic [W-1:0] age
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age <= MAX_V;
    end else if (!hold) begin
      if (load_one) begin
        age <= W'(1);
      end else if (age != MAX_V) begin
        age <= age + W'(1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - age-counter hazard unit with memory freeze and halt drain
// Ports: clk, rst_n (sync, active-low); decode fields id_valid, id_rs/id_rt(+_used),
//        id_rd, id_reg_write, id_mem_read, id_mem_write, id_sets_flags, id_branch,
//        id_br, id_hlt; update_PC, mem_stall; outputs pc_stall, if_id_stall,
//        id_flush, if_flush (combinational) and halted (registered, sticky).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ID_W       = 4,
  parameter int ALU_GAP        = DEF_ALU_GAP,
  parameter int LOAD_GAP       = DEF_LOAD_GAP,
  parameter int LOAD_STORE_GAP = DEF_LOAD_STORE_GAP,
  parameter int BR_GAP         = DEF_BR_GAP,
  parameter int FLAG_GAP       = DEF_FLAG_GAP,
  parameter int PIPE_DEPTH     = DEF_PIPE_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [REG_ID_W-1:0] id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_sets_flags,
  input  logic                id_branch,
  input  logic                id_br,
  input  logic                id_hlt,
  input  logic                update_PC,
  input  logic                mem_stall,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                id_flush,
  output logic                if_flush,
  output logic                halted
);

  localparam int NREG    = 2 ** REG_ID_W;
  localparam int AGE_MAX = imax(imax(imax(ALU_GAP, LOAD_GAP), imax(LOAD_STORE_GAP, BR_GAP)), FLAG_GAP);
  localparam int AGE_W   = age_w(AGE_MAX);
  localparam int FLAG_W  = age_w(FLAG_GAP);
  localparam int DCW     = age_w(PIPE_DEPTH - 1);

  logic [AGE_W-1:0]  age [NREG];
  logic [NREG-1:0]   kind;
  logic [FLAG_W-1:0] flag_age;

  halt_state_t       state_q, state_d;
  logic [DCW-1:0]    drain_q, drain_d;

  logic rd_write, issue, hazard, rs_haz, rt_haz, flag_haz;
  int   rs_gap, rt_gap;

  assign rd_write = id_reg_write && (id_rd != '0);

  // r0 is hard-wired and never a producer, so it always reads as ready.
  assign age[0] = AGE_W'(AGE_MAX);

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    hazard_age_ctr #(.W(AGE_W), .MAX(AGE_MAX)) u_age (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_one (issue && rd_write && (id_rd == REG_ID_W'(r))),
      .hold     (mem_stall),
      .age      (age[r])
    );
  end

  hazard_age_ctr #(.W(FLAG_W), .MAX(FLAG_GAP)) u_flag_age (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_one (issue && id_sets_flags),
    .hold     (mem_stall),
    .age      (flag_age)
  );

  // A newer writer simply overwrites the producer kind of the older one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kind <= '0;
    end else if (issue && rd_write) begin
      kind[id_rd] <= id_mem_read;
    end
  end

  // Checks use the pre-update ages, so "add r1,r1,r2" sees the previous r1 writer.
  always_comb begin
    rs_gap = (id_branch && id_br) ? BR_GAP
           : ((kind[id_rs] == KIND_LOAD) ? LOAD_GAP : ALU_GAP);
    if (id_mem_write) begin
      rt_gap = (kind[id_rt] == KIND_LOAD) ? LOAD_STORE_GAP : ALU_GAP;
    end else begin
      rt_gap = (kind[id_rt] == KIND_LOAD) ? LOAD_GAP : ALU_GAP;
    end
    rs_haz   = id_rs_used && (id_rs != '0) && (int'(age[id_rs]) < rs_gap);
    rt_haz   = id_rt_used && (id_rt != '0) && (int'(age[id_rt]) < rt_gap);
    flag_haz = id_branch && (int'(flag_age) < FLAG_GAP);
    hazard   = id_valid && (rs_haz || rt_haz || flag_haz);
    issue    = id_valid && !hazard && !mem_stall && (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (issue && id_hlt) begin
          state_d = DRAIN;
          drain_d = DCW'(PIPE_DEPTH - 1);
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          if (drain_q == '0) state_d = HALTED;
          else               drain_d = drain_q - DCW'(1);
        end
      end
      default: ;
    endcase
  end

  // Once halting, the front end is parked; the drain state takes precedence
  // over the memory freeze because nothing in IF/ID will ever issue again.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    id_flush    = 1'b0;
    if_flush    = 1'b0;
    halted      = 1'b0;
    if (rst_n) begin
      halted = (state_q == HALTED);
      if (state_q != RUN) begin
        pc_stall = 1'b1;
        if_flush = 1'b1;
      end else if (mem_stall) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        if_flush    = update_PC;
      end else begin
        if_id_stall = hazard;
        id_flush    = hazard;
        pc_stall    = hazard || (id_valid && id_hlt);
        if_flush    = update_PC;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       id_valid, id_rs_used, id_rt_used, id_reg_write, id_mem_read, id_mem_write;
  logic       id_sets_flags, id_branch, id_br, id_hlt, update_PC, mem_stall;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       pc_stall, if_id_stall, id_flush, if_flush, halted;

  // REG_ID_W=5, LOAD_GAP=3 instance
  logic       w_valid, w_rs_used, w_reg_write, w_mem_read;
  logic [4:0] w_rs, w_rd;
  logic       w_pc_stall, w_if_id_stall, w_id_flush, w_if_flush, w_halted;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_sets_flags(id_sets_flags), .id_branch(id_branch), .id_br(id_br), .id_hlt(id_hlt),
    .update_PC(update_PC), .mem_stall(mem_stall), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .id_flush(id_flush), .if_flush(if_flush), .halted(halted)
  );

  hazard_scoreboard #(.REG_ID_W(5), .LOAD_GAP(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .id_valid(w_valid), .id_rs(w_rs), .id_rt(5'd0),
    .id_rs_used(w_rs_used), .id_rt_used(1'b0), .id_rd(w_rd),
    .id_reg_write(w_reg_write), .id_mem_read(w_mem_read), .id_mem_write(1'b0),
    .id_sets_flags(1'b0), .id_branch(1'b0), .id_br(1'b0), .id_hlt(1'b0),
    .update_PC(1'b0), .mem_stall(1'b0), .pc_stall(w_pc_stall),
    .if_id_stall(w_if_id_stall), .id_flush(w_id_flush), .if_flush(w_if_flush), .halted(w_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                       input logic rs_u, input logic rt_u, input logic rw, input logic mr,
                       input logic mw, input logic fl, input logic b, input logic brr,
                       input logic h);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_used = rs_u; id_rt_used = rt_u; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = mw; id_sets_flags = fl; id_branch = b; id_br = brr; id_hlt = h;
  endtask

  task automatic bubble();
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b0; id_sets_flags = 1'b0; id_branch = 1'b0; id_br = 1'b0; id_hlt = 1'b0;
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt, input logic fl);
    drive(rs, rt, rd, 1, 1, 1, 0, 0, fl, 0, 0, 0);
  endtask

  task automatic lw(input logic [3:0] rd);
    drive(4'd0, 4'd0, rd, 1, 0, 1, 1, 0, 0, 0, 0, 0);
  endtask

  // Holds the driven instruction in decode until it issues; counts stall cycles.
  task automatic run_issue(output int stalls, output logic [2:0] first);
    stalls = 0;
    @(negedge clk);
    first = {pc_stall, if_id_stall, id_flush};
    while (if_id_stall && stalls < 20) begin
      stalls++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bubble();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int         n;
  logic [2:0] f;

  initial begin
    bubble();
    w_valid = 0; w_rs = '0; w_rd = '0; w_rs_used = 0; w_reg_write = 0; w_mem_read = 0;
    update_PC = 1'b0; mem_stall = 1'b0;

    // outputs forced low while in reset, whatever decode shows
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    update_PC = 1'b1; mem_stall = 1'b1;
    #2;
    chk("rst_outs", 32'({pc_stall, if_id_stall, id_flush, if_flush, halted}), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bubble(); update_PC = 1'b0; mem_stall = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", 32'({pc_stall, if_id_stall, id_flush, if_flush, halted}), 0);
    @(posedge clk); #1;

    // load-use: one bubble
    lw(4'd3);              run_issue(n, f); chk("lw3_stalls", 32'(n), 0);
    alu(4'd4, 4'd3, 4'd1, 0); run_issue(n, f);
    chk("lwuse_first", 32'(f), 3'b111);
    chk("lwuse_stalls", 32'(n), 1);
    // load feeding store data: no stall
    lw(4'd3);              run_issue(n, f); chk("lw3b_stalls", 32'(n), 0);
    drive(4'd0, 4'd3, 4'd0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    run_issue(n, f);       chk("lwsw_stalls", 32'(n), 0);

    // ALU -> BR on Rs: two bubbles; r0 as Rs: none
    alu(4'd5, 4'd1, 4'd2, 0); run_issue(n, f); chk("add5_stalls", 32'(n), 0);
    drive(4'd5, 4'd0, 4'd0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    run_issue(n, f);       chk("br5_stalls", 32'(n), 2);
    alu(4'd5, 4'd1, 4'd2, 0); run_issue(n, f);
    drive(4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    run_issue(n, f);       chk("br0_stalls", 32'(n), 0);

    // ALU -> dependent ALU back to back
    alu(4'd6, 4'd1, 4'd2, 0); run_issue(n, f);
    alu(4'd7, 4'd6, 4'd6, 0); run_issue(n, f); chk("alu_alu_stalls", 32'(n), 0);

    // flag setter -> B: one bubble; non-setter -> B: none
    alu(4'd6, 4'd1, 4'd2, 1); run_issue(n, f);
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_issue(n, f);       chk("sub_b_stalls", 32'(n), 1);
    alu(4'd6, 4'd1, 4'd2, 0); run_issue(n, f);
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_issue(n, f);       chk("xor_b_stalls", 32'(n), 0);

    // memory freeze holds ages; exactly one bubble remains afterwards
    lw(4'd2);              run_issue(n, f);
    alu(4'd7, 4'd2, 4'd1, 0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ms_outs", 32'({pc_stall, if_id_stall, id_flush}), 3'b110);
      @(posedge clk); #1;
    end
    mem_stall = 1'b0;
    run_issue(n, f);       chk("ms_after_stalls", 32'(n), 1);

    // redirect alongside a hazard: stall holds, fetched instruction squashed
    lw(4'd8);              run_issue(n, f);
    alu(4'd9, 4'd8, 4'd0, 0);
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    id_rs = 4'd8; id_rs_used = 1'b1; update_PC = 1'b1;
    #1;
    chk("redir_flush", 32'({if_flush, if_id_stall, id_flush}), 3'b111);
    run_issue(n, f);       chk("redir_stalls", 32'(n), 1);
    update_PC = 1'b0;
    @(negedge clk);
    chk("no_redir_flush", 32'(if_flush), 0);
    @(posedge clk); #1;

    // HLT: drain PIPE_DEPTH cycles then halted
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("hlt_decode", 32'({pc_stall, if_id_stall, id_flush, if_flush}), 4'b1000);
    @(posedge clk); #1;
    alu(4'd1, 4'd2, 4'd3, 0);
    #1;
    chk("drain_outs", 32'({pc_stall, if_id_stall, id_flush, if_flush, halted}), 5'b10010);
    n = 0;
    while (!halted && n < 20) begin @(posedge clk); #1; n++; end
    chk("halt_cycles", 32'(n), 4);
    repeat (3) @(posedge clk);
    #1;
    chk("halted_sticky", 32'({pc_stall, if_id_stall, id_flush, if_flush, halted}), 5'b10011);
    bubble();

    // HLT with two frozen cycles mid-drain
    do_reset();
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    bubble();
    n = 0;
    while (!halted && n < 20) begin
      mem_stall = (n == 1 || n == 2);
      @(posedge clk); #1; n++;
    end
    mem_stall = 1'b0;
    chk("halt_cycles_ms", 32'(n), 6);

    // reset in DRAIN abandons the halt
    do_reset();
    drive(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_drain_outs", 32'({pc_stall, if_id_stall, id_flush, if_flush, halted}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_drain_after", 32'({pc_stall, if_id_stall, id_flush, if_flush, halted}), 0);

    // wider instance: every register ready after reset, LOAD_GAP=3 gives two bubbles
    do_reset();
    for (int r = 1; r < 32; r++) begin
      w_valid = 1'b1; w_rs = 5'(r); w_rs_used = 1'b1;
      @(negedge clk);
      chk($sformatf("w_ready_r%0d", r), 32'(w_if_id_stall), 0);
      @(posedge clk); #1;
    end
    w_rs = 5'd0; w_rd = 5'd17; w_reg_write = 1'b1; w_mem_read = 1'b1;
    @(posedge clk); #1;
    w_rd = 5'd0; w_reg_write = 1'b0; w_mem_read = 1'b0; w_rs = 5'd17;
    n = 0;
    @(negedge clk);
    while (w_if_id_stall && n < 20) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("w_lw17_stalls", 32'(n), 2);
    w_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
